// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg: shared types and defaults for the UART transmit arbiter. Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_N            = 4;
  localparam int unsigned DEF_BUSY_TIMEOUT = 8;
  localparam int unsigned BIT_PERIOD       = 279;

  // Index width for N entries; a single entry still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_pick: rotating-priority picker, first set request at or after ptr. Rev 1.0
// ----------------------------------------------------------------------------
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned PW = idx_width(DEF_N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  win_o,
  output logic [PW-1:0] win_idx_o,
  output logic          any_o
);

  logic [PW:0] w_pos;

  // Scan from the farthest offset down so the nearest hit is the last write.
  always_comb begin
    w_pos     = '0;
    win_idx_o = '0;
    any_o     = |req_i;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      w_pos = {1'b0, ptr_i} + (PW+1)'(i);
      if (w_pos >= (PW+1)'(N)) begin
        w_pos = w_pos - (PW+1)'(N);
      end
      if (req_i[w_pos[PW-1:0]]) begin
        win_idx_o = w_pos[PW-1:0];
      end
    end
    win_o            = '0;
    win_o[win_idx_o] = any_o;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N producers. Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N            = DEF_N,
  parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N-1:0]   req_i,
  input  logic [8*N-1:0] req_data_i,
  output logic [N-1:0]   ack_o,
  output logic [N-1:0]   gnt_o,
  output logic           busy_o,
  output logic           err_o,
  output logic           tx_en_o,
  output logic [7:0]     tx_data_o,
  input  logic           tx_rdy_i
);

  localparam int unsigned PW = idx_width(N);
  localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    ack_q, ack_d;
  logic            err_q, err_d;
  logic            tx_en_q, tx_en_d;
  logic [7:0]      tx_data_q, tx_data_d;

  logic [N-1:0]    w_win;
  logic [PW-1:0]   w_idx;
  logic            w_any;
  logic [CW-1:0]   w_cnt_inc;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .win_o     (w_win),
    .win_idx_o (w_idx),
    .any_o     (w_any)
  );

  assign w_cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    err_d     = 1'b0;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (w_any && tx_rdy_i) begin
          gnt_d     = w_win;
          ack_d     = w_win;
          win_d     = w_idx;
          tx_data_d = req_data_i[{w_idx, 3'b000} +: 8];
          tx_en_d   = 1'b1;
          cnt_d     = '0;
          state_d   = ST_WAIT_BUSY;
        end
      end
      // rdy stays high for two edges after en, so only its fall is meaningful here.
      ST_WAIT_BUSY: begin
        if (!tx_rdy_i) begin
          state_d = ST_WAIT_DONE;
        end else if (w_cnt_inc == CW'(BUSY_TIMEOUT)) begin
          err_d   = 1'b1;
          gnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_rdy_i) begin
          gnt_d   = '0;
          ptr_d   = (win_q == PW'(N - 1)) ? '0 : win_q + PW'(1);
          state_d = ST_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign ack_o     = ack_q;
  assign gnt_o     = gnt_q;
  assign busy_o    = |gnt_q;
  assign err_o     = err_q;
  assign tx_en_o   = tx_en_q;
  assign tx_data_o = tx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter: scoreboard bench with a behavioural UART transmitter. Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  typedef struct {
    int         idx;
    logic [7:0] data;
    bit         timeout;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack, gnt;
  logic           busy, err, tx_en, tx_rdy;
  logic [7:0]     tx_data;

  int   n_checks, n_fail;
  int   m_ptr;
  int   tx_mode;
  int   bit_cycles;
  exp_t sb_q[$];
  bit   line_q[$];
  logic [7:0] bytes_m [N][4];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .BUSY_TIMEOUT(TO)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .req_data_i (req_data),
    .ack_o      (ack),
    .gnt_o      (gnt),
    .busy_o     (busy),
    .err_o      (err),
    .tx_en_o    (tx_en),
    .tx_data_o  (tx_data),
    .tx_rdy_i   (tx_rdy)
  );

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Transmitter model: samples en, drops rdy one edge later, reads tx_data per bit.
  int   t_phase = 0, t_cnt = 0, t_bit = 0;
  logic t_rdy = 1'b1;

  always @(posedge clk) begin
    if (!rst_n) begin
      t_phase <= 0;
      t_rdy   <= 1'b1;
    end else begin
      case (t_phase)
        0: if (tx_en && tx_mode == 0) t_phase <= 1;
        1: begin
          t_rdy   <= 1'b0;
          t_cnt   <= 0;
          t_bit   <= 0;
          t_phase <= 2;
        end
        default: begin
          if (t_cnt == bit_cycles / 2)
            line_q.push_back((t_bit == 0) ? 1'b0 : (t_bit == 9) ? 1'b1 : tx_data[3'(t_bit - 1)]);
          if (t_cnt == bit_cycles - 1) begin
            t_cnt <= 0;
            if (t_bit == 9) begin
              t_rdy   <= 1'b1;
              t_phase <= 0;
            end else begin
              t_bit <= t_bit + 1;
            end
          end else begin
            t_cnt <= t_cnt + 1;
          end
        end
      endcase
    end
  end

  assign tx_rdy = (tx_mode == 1) ? 1'b1 : (tx_mode == 2) ? 1'b0 : t_rdy;

  function automatic logic [31:0] line_bits();
    logic [31:0] v;
    v = '0;
    if (line_q.size() != 10) return 32'h8000_0000 | 32'(line_q.size());
    for (int k = 0; k < 10; k++) v[k] = line_q[k];
    return v;
  endfunction

  // Monitor: pops the scoreboard on every ack and follows the frame to its end.
  exp_t       cur;
  bit         in_frame = 1'b0;
  bit         stable;
  bit         en_prev = 1'b0;
  int         fcyc;
  logic [7:0] held;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      en_prev  = 1'b0;
    end else begin
      if (tx_en) check("tx_en_width", 32'(en_prev), 0);
      en_prev = tx_en;
      if (ack != 0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ack", 32'(ack), 0);
        end else begin
          cur = sb_q.pop_front();
          check("ack_owner", 32'(ack), 32'(1) << cur.idx);
          check("gnt_at_ack", 32'(gnt), 32'(ack));
          check("tx_data_at_ack", 32'(tx_data), 32'(cur.data));
          check("en_busy_at_ack", 32'({tx_en, busy}), 32'(2'b11));
          in_frame = 1'b1;
          fcyc     = 0;
          held     = tx_data;
          stable   = 1'b1;
          line_q.delete();
        end
      end else if (in_frame) begin
        fcyc++;
        if (gnt != 0) begin
          if (tx_data !== held || gnt !== N'(1 << cur.idx) || !busy) stable = 1'b0;
        end else begin
          in_frame = 1'b0;
          check("frame_stable", 32'(stable), 1);
          check("busy_clear", 32'(busy), 0);
          if (cur.timeout) begin
            check("err_on_timeout", 32'(err), 1);
            check("err_cycle", 32'(fcyc), TO);
          end else begin
            check("no_err", 32'(err), 0);
            check("serial_bits", line_bits(), 32'({1'b1, cur.data, 1'b0}));
          end
        end
      end else if (err) begin
        check("spurious_err", 32'(err), 0);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  // Each requester sends cnt bytes; the expected grant order is derived up front
  // from the rotation rule, since every pending requester waits at every pick.
  task automatic run_round(input int c0, input int c1, input int c2, input int c3,
                           input bit stuck, input int low_cycles, input int bitc,
                           input int first_byte);
    int cnt[N];
    int rem[N];
    int sidx[N];
    int total, first_idx, limit;
    bit done, saw_ack;
    cnt   = '{c0, c1, c2, c3};
    total = 0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 4; k++) bytes_m[i][k] = 8'($urandom);
      if (first_byte >= 0) bytes_m[i][0] = 8'(first_byte);
      rem[i]  = cnt[i];
      sidx[i] = 0;
      total  += cnt[i];
    end
    first_idx = 0;
    for (int n = 0; n < total; n++) begin
      for (int k = 0; k < N; k++) begin
        int r;
        r = (m_ptr + k) % N;
        if (rem[r] > 0) begin
          sb_q.push_back('{idx: r, data: bytes_m[r][cnt[r] - rem[r]], timeout: stuck});
          if (n == 0) first_idx = r;
          rem[r]--;
          if (!stuck) m_ptr = (r + 1) % N;
          break;
        end
      end
    end
    bit_cycles = bitc;
    tx_mode    = stuck ? 1 : (low_cycles > 0 ? 2 : 0);
    for (int i = 0; i < N; i++) begin
      req_data[8*i +: 8] = bytes_m[i][0];
      req[i]             = (cnt[i] > 0);
    end
    limit   = total * (12 * bitc + 40) + low_cycles + 50;
    done    = 1'b0;
    saw_ack = 1'b0;
    for (int cyc = 0; cyc < limit && !done; cyc++) begin
      @(negedge clk);
      if (low_cycles > 0) begin
        if (cyc < low_cycles && ack != 0) saw_ack = 1'b1;
        if (cyc == low_cycles) begin
          check("no_ack_while_rdy_low", 32'(saw_ack), 0);
          tx_mode = 0;
        end
        if (cyc == low_cycles + 1) check("grant_after_rdy", 32'(ack), 32'(1) << first_idx);
      end
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          sidx[i]++;
          if (sidx[i] < cnt[i]) req_data[8*i +: 8] = bytes_m[i][sidx[i]];
          else req[i] = 1'b0;
        end
      end
      done = (req == '0) && !busy && (sb_q.size() == 0) && (t_phase == 0);
    end
    check("round_complete", 32'(done), 1);
    tx_mode = 0;
    req     = '0;
  endtask

  initial begin
    bit got, saw;
    int c0, c1, c2, c3;
    n_checks   = 0;
    n_fail     = 0;
    m_ptr      = 0;
    tx_mode    = 0;
    bit_cycles = 8;
    req        = '0;
    req_data   = '0;
    rst_n      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({ack, gnt, busy, err, tx_en, tx_data}), 0);
    rst_n = 1'b1;

    run_round(0, 0, 1, 0, 1'b0, 0, 279, 8'hA5);
    do_reset();
    run_round(2, 1, 1, 1, 1'b0, 0, 16, -1);
    run_round(0, 2, 0, 2, 1'b0, 0, 12, -1);
    repeat (6) begin
      c0 = $urandom_range(0, 3);
      c1 = $urandom_range(0, 3);
      c2 = $urandom_range(0, 3);
      c3 = $urandom_range(0, 3);
      if (c0 + c1 + c2 + c3 == 0) c0 = 1;
      run_round(c0, c1, c2, c3, 1'b0, 0, $urandom_range(6, 24), -1);
    end

    // Reset in the middle of a long frame.
    do_reset();
    bit_cycles      = 279;
    req_data[7:0]   = 8'h3C;
    sb_q.push_back('{idx: 0, data: 8'h3C, timeout: 1'b0});
    req             = 4'b0001;
    got             = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ack[0]) got = 1'b1;
    end
    check("midframe_ack", 32'(got), 1);
    req = '0;
    repeat (1000) @(negedge clk);
    check("gnt_before_reset", 32'(gnt), 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", 32'({ack, gnt, busy, err, tx_en, tx_data}), 0);
    m_ptr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    saw   = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx_en || ack != 0) saw = 1'b1;
    end
    check("quiet_after_reset", 32'(saw), 0);

    run_round(1, 0, 0, 0, 1'b1, 0, 8, -1);
    run_round(1, 0, 0, 0, 1'b0, 0, 8, -1);

    tx_mode = 2;
    do_reset();
    run_round(0, 1, 0, 0, 1'b0, 30, 8, -1);

    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART `Transmitter` among `N` byte producers. It picks one pending requester, presents that byte to the transmitter, and starts the frame with a one-cycle enable. It holds the byte stable for the whole frame, because the transmitter samples `data_tx` per bit and does not latch it. It returns the grant only when the transmitter reports ready again. It sits between the producer blocks (debug dumpers, command responders) and the single `Transmitter` instance driving the UART pin.

## Interface
- `N`, default 4: number of requesters (2..8).
- `BUSY_TIMEOUT`, default 8: maximum cycles to wait for `tx_rdy` to fall after the enable.
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `req`  in  N: level request per requester; requester i holds it while its byte is pending.
- `req_data`  in  8*N: byte of requester i on bits [8i+7:8i]; stable while `req[i]` is high.
- `ack`  out  N: one-hot, one-cycle pulse when requester i's byte is captured.
- `gnt`  out  N: one-hot owner of the transmitter; high from capture until the frame ends.
- `busy`  out  1: high from capture until the frame ends (equals `|gnt`).
- `err`  out  1: one-cycle pulse on busy timeout.
- `tx_en`  out  1: to `Transmitter.en`; one-cycle pulse.
- `tx_data`  out  8: to `Transmitter.data_tx`; held for the whole frame.
- `tx_rdy`  in  1: from `Transmitter.rdy`.

## Operation
- Reset values (async, `rst_n` low): state IDLE, `ack`=0, `gnt`=0, `busy`=0, `err`=0, `tx_en`=0, `tx_data`=8'h00, rotation pointer `ptr`=0, timeout counter=0.
- States:
  - IDLE: if `|req` and `tx_rdy`, winner w = first set `req` bit scanning `ptr`, `ptr+1`, … mod N. On the same edge: `gnt`<=onehot(w), `ack`<=onehot(w), `busy`<=1, `tx_data`<=byte w, `tx_en`<=1; go to WAIT_BUSY. Otherwise stay in IDLE.
  - WAIT_BUSY: on the first edge, `tx_en`<=0 and `ack`<=0.
    - If `tx_rdy`=0: go to WAIT_DONE.
    - Else if the counter reaches `BUSY_TIMEOUT`: pulse `err`, clear `gnt`/`busy`, go to IDLE; `ptr` is unchanged.
  - WAIT_DONE: when `tx_rdy`=1, `gnt`<=0, `busy`<=0, `ptr`<=(w+1) mod N; go to IDLE.
- `tx_rdy` is ignored in WAIT_BUSY until it has gone low. The transmitter's `rdy` stays high for two edges after `en`, so it must not be read as frame end.
- `tx_data` changes only on a capture edge; it never changes in WAIT_BUSY or WAIT_DONE.
- Deasserting `req[w]` after `ack` does not affect the frame. Requester w must drop `req` or present its next byte in the cycle after `ack`.
- Asserting `req[w]` again during the frame is queued like any other request.
- Requests arriving in WAIT_BUSY or WAIT_DONE wait for IDLE; no request is lost and none is acked twice.
- Rotation: the last winner gets lowest priority on the next pick. With a single requester, back-to-back bytes are granted to it without gaps beyond the handshake.
- `tx_rdy`=0 in IDLE (for example, the transmitter is still in a frame after the arbiter's reset): no grant is made.
- Reset mid-frame returns everything to reset values immediately. The transmitter is reset by its own synchronous reset; no `ack` is re-issued.

## Timing
- Edge E0 (IDLE, request and `tx_rdy` high): `ack`, `gnt`, `tx_en` and `tx_data` are visible after E0.
- `tx_en` is low after E1, so it is exactly one cycle wide.
- The transmitter samples `en` at E1, and `rdy` falls after E2. The arbiter enters WAIT_DONE after E3.
- With 279 cycles per bit, `tx_rdy` returns high about 2790 cycles after E1. `gnt` and `busy` clear on the first edge that sees `tx_rdy`=1.
- The next capture is possible on the edge after that (2 cycles of IDLE overhead at most).
- The timeout counter clears on entering WAIT_BUSY and counts each WAIT_BUSY cycle. `err` fires on the edge where the count reaches `BUSY_TIMEOUT`, i.e. no earlier than `BUSY_TIMEOUT` cycles after E0.

## Structure
- Shared package `uart_pkg`: state encoding (IDLE=2'd0, WAIT_BUSY=2'd1, WAIT_DONE=2'd2), default `N`, `BUSY_TIMEOUT`, bit-period constant 279.
- Sub-module `rr_pick`: combinational rotating priority picker (inputs `req`, `ptr`; outputs one-hot `win`, index `win_idx`, `any`).
- The top holds the FSM, pointer, timeout counter and output registers.

## Test plan
- Single request: `req`=4'b0100, byte 8'hA5, `tx_rdy` modelled by a real `Transmitter` → `ack[2]` pulses once, `tx_en` is one cycle wide, the serial line carries 0,1,0,1,0,0,1,0,1,1 (LSB first), `gnt[2]` clears after the stop bit.
- Simultaneous `req`=4'b1111 from reset → grants in order 0,1,2,3,0; each `ack` is one cycle; `tx_data` is stable across every frame.
- `req[1]` and `req[3]` held continuously → grants alternate 1,3,1,3; no requester is starved.
- Reset mid-frame: `rst_n` low at 1000 cycles into a frame → all outputs are 0 asynchronously; after release with `req`=0, no `tx_en`.
- Stuck `tx_rdy`=1 (transmitter stub ignores `en`), `req`=4'b0001 → `err` pulses 8 cycles after capture, `gnt` clears, and the next request is granted normally.
- `tx_rdy`=0 at arbiter reset release with `req`=4'b0010 → no `ack` until `tx_rdy` rises, then a grant on the next edge.
